// File: rtl/video_types_pkg.sv
// Shared video constants and types for the whizgraphics sprite pipeline.
// Holds the OAM scan sizing, object geometry constants, the selected-slot
// payload and the OAM scan state encoding.
package video_types;

    localparam int unsigned NUM_OBJECTS  = 40;
    localparam int unsigned MAX_PER_LINE = 10;
    localparam int unsigned IDX_W        = $clog2(NUM_OBJECTS);
    localparam int unsigned CNT_W        = $clog2(MAX_PER_LINE + 1);

    localparam int unsigned OBJ_Y_OFFSET = 16;
    localparam int unsigned OBJ_H_SHORT  = 8;
    localparam int unsigned OBJ_H_TALL   = 16;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [7:0]       x;
    } obj_slot_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/whizgraphics_sprite_sort_list.sv
// X-sorted list of selected sprites for one scanline.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   clear              empty the list and drop the overflow flag
//   insert_en          new_slot is a hit to be inserted this cycle
//   new_slot           OAM index + X of the hit
//   count              number of valid slots
//   overflow           a hit arrived while the list was full
//   sel_index, sel_x   flattened slot contents, slot 0 lowest X
module whizgraphics_sprite_sort_list
    import video_types::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic                          insert_en,
    input  obj_slot_t                     new_slot,
    output logic [CNT_W-1:0]              count,
    output logic                          overflow,
    output logic [MAX_PER_LINE*IDX_W-1:0] sel_index,
    output logic [MAX_PER_LINE*8-1:0]     sel_x
);

    obj_slot_t               slots_q [MAX_PER_LINE];
    obj_slot_t               slots_d [MAX_PER_LINE];
    logic [CNT_W-1:0]        count_q;
    logic                    overflow_q;
    logic                    full;
    logic [MAX_PER_LINE-1:0] keep;
    logic [MAX_PER_LINE-1:0] prev_keep;

    // Parallel insert: valid slots with x <= new x stay put (this keeps equal-X
    // entries in OAM order); the first slot past them takes the new entry and
    // every later valid slot moves up one position.
    always_comb begin
        full = (count_q == CNT_W'(MAX_PER_LINE));
        for (int i = 0; i < MAX_PER_LINE; i++) begin
            keep[i] = (CNT_W'(i) < count_q) && (slots_q[i].x <= new_slot.x);
        end
        prev_keep = {keep[MAX_PER_LINE-2:0], 1'b1};
        for (int i = 0; i < MAX_PER_LINE; i++) begin
            slots_d[i] = slots_q[i];
            if (!keep[i] && (CNT_W'(i) <= count_q)) begin
                slots_d[i] = prev_keep[i] ? new_slot : slots_q[(i > 0) ? i - 1 : 0];
            end
        end
    end

    // Slot, count and sticky overflow registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < MAX_PER_LINE; i++) slots_q[i] <= '0;
        end else if (clear) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < MAX_PER_LINE; i++) slots_q[i] <= '0;
        end else if (insert_en) begin
            if (full) begin
                overflow_q <= 1'b1;
            end else begin
                count_q <= count_q + CNT_W'(1);
                for (int i = 0; i < MAX_PER_LINE; i++) slots_q[i] <= slots_d[i];
            end
        end
    end

    // Flatten slot registers onto the output buses
    always_comb begin
        sel_index = '0;
        sel_x     = '0;
        for (int i = 0; i < MAX_PER_LINE; i++) begin
            sel_index[i*IDX_W +: IDX_W] = slots_q[i].index;
            sel_x[i*8 +: 8]             = slots_q[i].x;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/whizgraphics_oam_scan.sv
// Per-scanline OAM search: walks every OAM entry after a start pulse, keeps
// up to MAX_PER_LINE sprites overlapping the requested line, sorted by X.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   start, line, tall    scan request (line/tall latched when accepted)
//   oam_rd_en, oam_addr  OAM read port, data returns one cycle later
//   oam_y, oam_x         entry Y/X bytes
//   busy, done           scan in progress / one-cycle results-valid pulse
//   count, overflow      selected sprite count / more hits than slots
//   sel_index, sel_x     selected OAM indices and X bytes, slot 0 first
module whizgraphics_oam_scan
    import video_types::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [7:0]                    line,
    input  logic                          tall_mode,
    output logic                          oam_rd_en,
    output logic [IDX_W-1:0]              oam_addr,
    input  logic [7:0]                    oam_y,
    input  logic [7:0]                    oam_x,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              count,
    output logic                          overflow,
    output logic [MAX_PER_LINE*IDX_W-1:0] sel_index,
    output logic [MAX_PER_LINE*8-1:0]     sel_x
);

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic             rd_en_q, rd_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic [7:0]       line_q;
    logic             tall_q;
    logic             eval_q;
    logic [IDX_W-1:0] eval_idx_q;
    logic [8:0]       line_top;
    logic [8:0]       y_end;
    logic             hit;
    obj_slot_t        hit_slot;

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_en_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_SCAN;
                    addr_d  = '0;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (rd_en_q) begin
                    // Keep reading until the last entry has been issued
                    if (addr_q != IDX_W'(NUM_OBJECTS - 1)) begin
                        addr_d  = addr_q + IDX_W'(1);
                        rd_en_d = 1'b1;
                    end
                end else begin
                    // Last entry is being evaluated this cycle
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Scan parameters and the read-data alignment stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q     <= '0;
            tall_q     <= 1'b0;
            eval_q     <= 1'b0;
            eval_idx_q <= '0;
        end else begin
            if (accept) begin
                line_q <= line;
                tall_q <= tall_mode;
            end
            eval_q     <= rd_en_q;
            eval_idx_q <= addr_q;
        end
    end

    // Vertical overlap test; 9 bits so Y+height never wraps
    always_comb begin
        line_top       = 9'(line_q) + 9'(OBJ_Y_OFFSET);
        y_end          = 9'(oam_y) + (tall_q ? 9'(OBJ_H_TALL) : 9'(OBJ_H_SHORT));
        hit            = eval_q && (line_top >= 9'(oam_y)) && (line_top < y_end);
        hit_slot.index = eval_idx_q;
        hit_slot.x     = oam_x;
    end

    whizgraphics_sprite_sort_list u_sort_list (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (accept),
        .insert_en (hit),
        .new_slot  (hit_slot),
        .count     (count),
        .overflow  (overflow),
        .sel_index (sel_index),
        .sel_x     (sel_x)
    );

    assign oam_rd_en = rd_en_q;
    assign oam_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_whizgraphics_oam_scan.sv
// Bench for whizgraphics_oam_scan: OAM memory model, scoreboard of expected
// scan results built from a list-and-sort reference, and a done monitor.
module tb_whizgraphics_oam_scan;
    import video_types::*;

    typedef struct packed {
        logic [3:0]      cnt;
        logic            ovf;
        logic [9:0][5:0] idx;
        logic [9:0][7:0] x;
        logic [31:0]     cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  line;
    logic        tall_mode;
    logic        oam_rd_en;
    logic [5:0]  oam_addr;
    logic [7:0]  oam_y;
    logic [7:0]  oam_x;
    logic        busy;
    logic        done;
    logic [3:0]  count;
    logic        overflow;
    logic [59:0] sel_index;
    logic [79:0] sel_x;

    int   m_y [40];
    int   m_x [40];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t exp_q [$];
    exp_t me;

    whizgraphics_oam_scan dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .line      (line),
        .tall_mode (tall_mode),
        .oam_rd_en (oam_rd_en),
        .oam_addr  (oam_addr),
        .oam_y     (oam_y),
        .oam_x     (oam_x),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .overflow  (overflow),
        .sel_index (sel_index),
        .sel_x     (sel_x)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // OAM with one cycle of read latency
    always @(posedge clk) begin
        if (oam_rd_en) begin
            oam_y <= 8'(m_y[oam_addr]);
            oam_x <= 8'(m_x[oam_addr]);
        end
    end

    task automatic check(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: collect hits in OAM order, keep the first ten, sort by (x, index)
    function automatic exp_t model(input int ln, input bit tl);
        exp_t e;
        int   hi[$];
        int   top;
        int   h;
        int   tmp;
        e   = '0;
        top = ln + 16;
        h   = tl ? 16 : 8;
        for (int k = 0; k < 40; k++)
            if (top >= m_y[k] && top < m_y[k] + h) hi.push_back(k);
        e.ovf = (hi.size() > 10);
        while (hi.size() > 10) void'(hi.pop_back());
        for (int a = 0; a < hi.size(); a++)
            for (int b = a + 1; b < hi.size(); b++)
                if (m_x[hi[b]] * 64 + hi[b] < m_x[hi[a]] * 64 + hi[a]) begin
                    tmp = hi[a]; hi[a] = hi[b]; hi[b] = tmp;
                end
        e.cnt = 4'(hi.size());
        for (int a = 0; a < hi.size(); a++) begin
            e.idx[a] = 6'(hi[a]);
            e.x[a]   = 8'(m_x[hi[a]]);
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest expected scan
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                me = exp_q.pop_front();
                check("done_cycle", cyc, me.cyc);
                check("done_busy", busy, 1);
                check("count", count, me.cnt);
                check("overflow", overflow, me.ovf);
                for (int a = 0; a < 10; a++) begin
                    if (a < me.cnt) begin
                        check($sformatf("sel_index[%0d]", a), sel_index[a*6 +: 6], me.idx[a]);
                        check($sformatf("sel_x[%0d]", a), sel_x[a*8 +: 8], me.x[a]);
                    end
                end
            end
        end
    end

    task automatic clear_oam();
        for (int k = 0; k < 40; k++) begin
            m_y[k] = 0;
            m_x[k] = 0;
        end
    endtask

    // Issue one scan from a negedge+1 slot; optional stray start at T+stray
    task automatic do_scan(input int ln, input bit tl, input int stray);
        exp_t e;
        bit   seen;
        e     = model(ln, tl);
        e.cyc = 32'(cyc + 42);
        exp_q.push_back(e);
        line      = 8'(ln);
        tall_mode = tl;
        start     = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_count", count, 0);
        check("t1_overflow", overflow, 0);
        check("t1_rd_en", oam_rd_en, 1);
        check("t1_addr", oam_addr, 0);
        if (stray > 1) begin
            repeat (stray - 1) @(negedge clk);
            #1;
            start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("done_timeout", seen, 1);
        if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk); #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        line      = '0;
        tall_mode = 1'b0;
        clear_oam();
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", oam_rd_en, 0);
        check("rst_addr", oam_addr, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sel_index", (sel_index == '0), 1);
        check("rst_sel_x", (sel_x == '0), 1);
        reset_n = 1'b1;
        @(negedge clk); #1;

        // Single sprite
        m_y[5] = 26; m_x[5] = 40;
        do_scan(10, 1'b0, 0);

        // Height edges
        do_scan(17, 1'b0, 0);
        do_scan(18, 1'b0, 0);
        do_scan(25, 1'b1, 0);
        do_scan(26, 1'b1, 0);
        clear_oam();
        m_y[1] = 0; m_x[1] = 9;
        m_y[2] = 159; m_x[2] = 77;
        do_scan(0, 1'b1, 0);
        do_scan(143, 1'b1, 0);

        // Sort with equal X
        clear_oam();
        m_y[3] = 16; m_x[3] = 50;
        m_y[7] = 16; m_x[7] = 20;
        m_y[9] = 16; m_x[9] = 50;
        do_scan(0, 1'b0, 0);

        // Overflow, then an empty line back to back
        clear_oam();
        for (int k = 0; k < 12; k++) begin
            m_y[k] = 60;
            m_x[k] = 200 - 10 * k;
        end
        do_scan(50, 1'b0, 0);
        do_scan(100, 1'b0, 0);

        // Stray start mid-scan is ignored
        do_scan(50, 1'b1, 5);

        // Reset in the middle of a scan
        line      = 8'd50;
        tall_mode = 1'b0;
        start     = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (19) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_count", count, 0);
        check("abort_overflow", overflow, 0);
        check("abort_rd_en", oam_rd_en, 0);
        check("abort_sel_index", (sel_index == '0), 1);
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        do_scan(50, 1'b0, 0);

        // Random OAM contents and lines
        for (int it = 0; it < 30; it++) begin
            int ln;
            ln = int'($urandom_range(0, 153));
            for (int k = 0; k < 40; k++) begin
                if (($urandom_range(0, 2) == 0) || (it % 3 == 0)) m_y[k] = int'($urandom_range(0, 255));
                else begin
                    m_y[k] = ln + 16 - int'($urandom_range(0, 17));
                    if (m_y[k] < 0) m_y[k] = 0;
                end
                m_x[k] = ($urandom_range(0, 3) == 0) ? 50 : int'($urandom_range(0, 255));
            end
            do_scan(ln, 1'($urandom_range(0, 1)), 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
